// File: rtl/dice_roller_mux_display.sv
// Rolls 1..8 dice of a DIP-selected type, sums them, shows the sum on a muxed 7-seg display.
// Optional ROLL_ANIM_EN: spinning-segment animation on all digits while a roll is in progress.
module dice_roller_mux_display #(
  parameter int          N_DIGITS    = 4,
  parameter int          REFRESH_DIV = 1000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                roll,
  input  logic [7:0]          dip_switch,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] an,
  output logic                busy,
  output logic [9:0]          result,
  output logic                result_valid
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, DRAW, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [2:0]          roll_sync_q, roll_sync_d;
  logic [6:0]          sides_q, sides_d, mask_q, mask_d;
  logic [3:0]          remaining_q, remaining_d;
  logic [9:0]          acc_q, acc_d, bin_q, bin_d;
  logic [11:0]         bcd_w_q, bcd_w_d, disp_bcd_q, disp_bcd_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                busy_q, busy_d, result_valid_q, result_valid_d;
  logic [9:0]          result_q, result_d;
  logic [CW-1:0]       refresh_cnt_q, refresh_cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic                roll_edge, roll_start, accept;
  logic [6:0]          cand, dip_sides, dip_mask;
  logic [9:0]          acc_sum;
  logic [11:0]         dd_adj;
  logic [3:0]          ones, tens, hund;
  logic                unused_dip;

  assign unused_dip = ^dip_switch[7:6];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // roll_sync_q: [0]/[1] synchroniser, [2] previous synced level for edge detect
  assign roll_sync_d = {roll_sync_q[1:0], roll};
  assign roll_edge   = roll_sync_q[1] & ~roll_sync_q[2];
  assign roll_start  = (state_q == IDLE) && roll_edge;

  assign lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign cand    = lfsr_q[6:0] & mask_q;
  assign accept  = cand < sides_q;
  assign acc_sum = acc_q + {3'b000, cand} + 10'd1;

  always_comb begin
    dip_sides = 7'd4;
    dip_mask  = 7'd3;
    case (dip_switch[2:0])
      3'd0: begin dip_sides = 7'd4;   dip_mask = 7'd3;   end
      3'd1: begin dip_sides = 7'd6;   dip_mask = 7'd7;   end
      3'd2: begin dip_sides = 7'd8;   dip_mask = 7'd7;   end
      3'd3: begin dip_sides = 7'd10;  dip_mask = 7'd15;  end
      3'd4: begin dip_sides = 7'd12;  dip_mask = 7'd15;  end
      3'd5: begin dip_sides = 7'd20;  dip_mask = 7'd31;  end
      3'd6: begin dip_sides = 7'd100; dip_mask = 7'd127; end
      default: begin dip_sides = 7'd2; dip_mask = 7'd1;  end
    endcase
  end

  // double-dabble: add 3 to any digit >= 5, then shift one binary bit in
  always_comb begin
    dd_adj = bcd_w_q;
    if (bcd_w_q[3:0]  >= 4'd5) dd_adj[3:0]  = bcd_w_q[3:0]  + 4'd3;
    if (bcd_w_q[7:4]  >= 4'd5) dd_adj[7:4]  = bcd_w_q[7:4]  + 4'd3;
    if (bcd_w_q[11:8] >= 4'd5) dd_adj[11:8] = bcd_w_q[11:8] + 4'd3;
  end

  always_comb begin
    state_d        = state_q;
    sides_d        = sides_q;
    mask_d         = mask_q;
    remaining_d    = remaining_q;
    acc_d          = acc_q;
    bin_d          = bin_q;
    bcd_w_d        = bcd_w_q;
    bit_cnt_d      = bit_cnt_q;
    busy_d         = busy_q;
    result_d       = result_q;
    disp_bcd_d     = disp_bcd_q;
    result_valid_d = 1'b0;
    case (state_q)
      IDLE: if (roll_edge) begin
        sides_d     = dip_sides;
        mask_d      = dip_mask;
        remaining_d = {1'b0, dip_switch[5:3]} + 4'd1;
        acc_d       = '0;
        busy_d      = 1'b1;
        state_d     = DRAW;
      end
      DRAW: if (accept) begin
        acc_d       = acc_sum;
        remaining_d = remaining_q - 4'd1;
        if (remaining_q == 4'd1) begin
          bin_d     = acc_sum;
          bcd_w_d   = '0;
          bit_cnt_d = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        {bcd_w_d, bin_d} = {dd_adj[10:0], bin_q, 1'b0};
        bit_cnt_d        = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd9) state_d = DONE;
      end
      DONE: begin
        result_d       = acc_q;
        disp_bcd_d     = bcd_w_q;
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ones = disp_bcd_q[3:0];
  assign tens = disp_bcd_q[7:4];
  assign hund = disp_bcd_q[11:8];

`ifdef ROLL_ANIM_EN
  localparam int ACW = $clog2(N_DIGITS * REFRESH_DIV);
  localparam logic [ACW-1:0] ANIM_MAX = ACW'(N_DIGITS * REFRESH_DIV - 1);
  logic [ACW-1:0] anim_cnt_q, anim_cnt_d;
  logic [2:0]     spin_q, spin_d;

  always_comb begin
    anim_cnt_d = anim_cnt_q + ACW'(1);
    spin_d     = spin_q;
    if (roll_start) begin
      anim_cnt_d = '0;
      spin_d     = '0;
    end else if (anim_cnt_q == ANIM_MAX) begin
      anim_cnt_d = '0;
      spin_d     = (spin_q == 3'd5) ? 3'd0 : spin_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anim_cnt_q <= '0;
      spin_q     <= '0;
    end else begin
      anim_cnt_q <= anim_cnt_d;
      spin_q     <= spin_d;
    end
  end
`endif

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CW'(1);
    idx_d         = idx_q;
    if (refresh_cnt_q == CNT_MAX) begin
      refresh_cnt_d = '0;
      idx_d         = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    if (idx_q == IW'(0))      seg_d = seg7(ones);
    else if (idx_q == IW'(1)) seg_d = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg7(tens);
    else if (idx_q == IW'(2)) seg_d = (hund == 4'd0) ? SEG_BLANK : seg7(hund);
    else                      seg_d = SEG_BLANK;
`ifdef ROLL_ANIM_EN
    if (busy_q) seg_d = ~(7'b0000001 << spin_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_SEED;
      roll_sync_q    <= '0;
      sides_q        <= '0;
      mask_q         <= '0;
      remaining_q    <= '0;
      acc_q          <= '0;
      bin_q          <= '0;
      bcd_w_q        <= '0;
      bit_cnt_q      <= '0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      disp_bcd_q     <= '0;
      result_valid_q <= 1'b0;
      refresh_cnt_q  <= '0;
      idx_q          <= '0;
      an_q           <= '1;
      seg_q          <= SEG_BLANK;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      roll_sync_q    <= roll_sync_d;
      sides_q        <= sides_d;
      mask_q         <= mask_d;
      remaining_q    <= remaining_d;
      acc_q          <= acc_d;
      bin_q          <= bin_d;
      bcd_w_q        <= bcd_w_d;
      bit_cnt_q      <= bit_cnt_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      disp_bcd_q     <= disp_bcd_d;
      result_valid_q <= result_valid_d;
      refresh_cnt_q  <= refresh_cnt_d;
      idx_q          <= idx_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dice_roller_mux_display.sv
// Scoreboard bench for dice_roller_mux_display: LFSR cycle model predicts every sum and its timing.
module tb_dice_roller_mux_display;
  localparam int          N_DIGITS    = 4;
  localparam int          REFRESH_DIV = 4;
  localparam logic [15:0] SEED        = 16'hACE1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                roll = 1'b0;
  logic [7:0]          dip_switch = 8'h00;
  logic [6:0]          seg;
  logic [N_DIGITS-1:0] an;
  logic                busy;
  logic [9:0]          result;
  logic                result_valid;

  dice_roller_mux_display #(
    .N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .roll(roll), .dip_switch(dip_switch),
    .seg(seg), .an(an), .busy(busy), .result(result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; int cyc; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;
  int cur_sum = 0;
  logic [15:0] m_lfsr = SEED;
  int sides_tab[8] = '{4, 6, 8, 10, 12, 20, 100, 2};
  int mask_tab[8]  = '{3, 7, 7, 15, 15, 31, 127, 1};
  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [15:0] nxt(input logic [15:0] l);
    logic [15:0] taps = 16'b1011_0100_0000_0000;
    nxt = {1'b0, l[15:1]} ^ (l[0] ? taps : 16'h0000);
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= !rst_n ? SEED : nxt(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_idx(input int c);
    exp_idx = ((c - rel - 1) / REFRESH_DIV) % N_DIGITS;
  endfunction

  function automatic logic [3:0] exp_an(input int c);
    logic [3:0] one = 4'b0001;
    exp_an = ~(one << exp_idx(c));
  endfunction

  function automatic logic [6:0] exp_seg(input int c, input int val);
    int h, t, o;
    h = val / 100; t = (val / 10) % 10; o = val % 10;
    case (exp_idx(c))
      0:       exp_seg = seg_tab[o];
      1:       exp_seg = (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
      2:       exp_seg = (h == 0) ? 7'h7F : seg_tab[h];
      default: exp_seg = 7'h7F;
    endcase
  endfunction

  task automatic idle_check(input int n);
    int c;
    repeat (n) begin
      @(negedge clk);
      c = cyc;
      check("idle_an", an, exp_an(c));
      check("idle_seg", seg, exp_seg(c, cur_sum));
      check("idle_busy", busy, 0);
    end
  endtask

  // Drives one roll; extra = second press + dip change mid-DRAW, abort = reset mid-CONV
  task automatic do_roll(input logic [7:0] d, input bit extra, input bit abort);
    int c0, c, n, sum, rem, sides, mask, cand, v, win_end, pulses, lo, hi;
    bit aborted;
    logic [15:0] l;
    logic [6:0] one7;
    exp_t e;
    c0 = cyc; dip_switch = d; roll = 1'b1;
    sides = sides_tab[d[2:0]]; mask = mask_tab[d[2:0]]; rem = int'(d[5:3]) + 1;
    lo = rem; hi = rem * sides;
    l = m_lfsr;
    repeat (3) l = nxt(l);
    n = 0; sum = 0;
    while (rem > 0) begin
      cand = int'(l[6:0]) & mask;
      n++;
      if (cand < sides) begin sum += cand + 1; rem--; end
      l = nxt(l);
    end
    v = c0 + 14 + n;
    if (!abort) sb.push_back('{sum, v});
    win_end = abort ? c0 + 6 + n : v;
    pulses = 0; aborted = 1'b0; one7 = 7'b0000001;
    for (int k = 0; k < v - c0 + 20; k++) begin
      @(negedge clk);
      c = cyc;
      if (c == c0 + 2) roll = 1'b0;
      if (extra && c == c0 + 4) begin roll = 1'b1; dip_switch = 8'b00_000_000; end
      if (extra && c == c0 + 6) roll = 1'b0;
      if (abort && c == c0 + 7 + n) begin
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_an", an, 4'hF);
        check("abort_seg", seg, 7'h7F);
        rst_n = 1'b1; rel = c; cur_sum = 0; aborted = 1'b1;
      end
      if (!aborted) begin
        if (c == c0 + 2) check("busy_pre", busy, 0);
        if (c >= c0 + 3 && c < win_end + 1 && c < v) check("busy_on", busy, 1);
        if (!abort && c == v) check("busy_off", busy, 0);
        if (c >= c0 + 4 && c <= win_end) begin
`ifdef ROLL_ANIM_EN
          check("anim_seg", seg, ~(one7 << (((c - c0 - 4) / 16) % 6)));
`else
          check("hold_seg", seg, exp_seg(c, cur_sum));
`endif
        end
      end
      if (abort && c == c0 + 6 + n) rst_n = 1'b0;
      if (result_valid === 1'b1) begin
        pulses++;
        if (sb.size() == 0) check("rv_spurious", result_valid, 0);
        else begin
          e = sb.pop_front();
          check("result", result, e.sum);
          check("rv_cycle", c, e.cyc);
        end
      end
    end
    check("rv_pulses", pulses, abort ? 0 : 1);
    if (!abort) begin
      check("result_range", (int'(result) >= lo && int'(result) <= hi), 1);
      cur_sum = sum;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 4'hF);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    rst_n = 1'b1; rel = cyc;
    idle_check(16);
    check("idle_result", result, 0);

    do_roll(8'b00_000_111, 1'b0, 1'b0);
    idle_check(16);

    do_roll(8'b00_111_110, 1'b1, 1'b0);
    idle_check(16);

    do_roll(8'b00_000_111, 1'b0, 1'b1);
    idle_check(8);

    do_roll(8'b00_001_000, 1'b0, 1'b0);
    idle_check(16);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
